// File: rtl/tb_stim_mux_pkg.sv
// -----------------------------------------------------------------------------
// tb_stim_pkg
// Shared types and helpers for the stimulus multiplexer:
//   ch_width()   - width of a channel index, never narrower than one bit
//   wd_width()   - width of a watchdog counter able to hold 0..timeout
//   cnt_max()    - all-ones saturation value for a counter of a given width
//   out_state_e  - output register occupancy
//   wd_state_e   - stall watchdog states
// -----------------------------------------------------------------------------
package tb_stim_pkg;

    // A single channel still needs a one-bit tag so out_ch is never zero width.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

    // Computed in 64 bits and truncated by the caller; a 64-bit request
    // wraps the shift to zero and the subtraction yields all ones.
    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    typedef enum logic [1:0] {
        WD_IDLE     = 2'd0,
        WD_COUNTING = 2'd1,
        WD_TRIPPED  = 2'd2
    } wd_state_e;

endpackage

// File: rtl/tb_stim_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The search for a requester starts at the internal
// pointer; after a grant to channel g the pointer moves to g+1 (mod NUM_CH).
// Without a grant the pointer holds.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (pointer to channel 0)
//   req        in   NUM_CH request vector
//   en         in   arbitration enable; no grant is issued while low
//   grant      out  NUM_CH one-hot grant (all zero when none)
//   grant_idx  out  CH_W index of the granted channel (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import tb_stim_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr_q;
    logic            found;

    // Walk the channels in order ptr, ptr+1, ... and take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            logic [CH_W-1:0] cand;
            cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            if (grant_idx == CH_W'(NUM_CH - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_idx + CH_W'(1);
            end
        end
    end

endmodule

// File: rtl/tb_stim_mux.sv
// -----------------------------------------------------------------------------
// tb_stim_mux
// Merges NUM_CH valid/ready stimulus channels into a single stream towards
// the DUT. A one-entry output register is refilled round-robin from the
// requesting channels; every beat carries its source channel. Accepted beats
// are counted per channel (saturating), and a watchdog flags a stream that
// has been stalled by the DUT for TIMEOUT consecutive cycles.
// Ports:
//   tb_clk       in   clock, all state on rising edge
//   tb_rst_n     in   asynchronous active-low reset
//   ch_valid     in   NUM_CH per-channel request
//   ch_data      in   NUM_CH*DATA_W payloads, channel i at [i*DATA_W +: DATA_W]
//   ch_ready     out  NUM_CH per-channel accept, at most one bit high
//   out_valid    out  output beat present
//   out_data     out  DATA_W output payload
//   out_ch       out  CH_W source channel of out_data
//   out_ready    in   DUT accept
//   ch_count     out  NUM_CH*CNT_W accepted beats per channel
//   timeout_err  out  sticky stall watchdog flag
//   clr_err      in   synchronous clear of timeout_err and ch_count
// -----------------------------------------------------------------------------
module tb_stim_mux
    import tb_stim_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int DATA_W  = 32,
    parameter  int CNT_W   = 16,
    parameter  int TIMEOUT = 1024,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                     tb_clk,
    input  logic                     tb_rst_n,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready,
    output logic [NUM_CH*CNT_W-1:0]  ch_count,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    // ------------------------------------------------------------------
    // Channel unpacking
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ch_data_arr [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data_arr[gi] = ch_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output stage and arbitration
    // ------------------------------------------------------------------
    out_state_e        out_state_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;

    logic              load_en;
    logic              arb_en;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              gnt_any;

    // The register can take a new beat when it is empty or is being drained
    // this cycle; this is the only path from out_ready to ch_ready.
    assign load_en = (out_state_q == OUT_EMPTY) || out_ready;

    // Gating with the reset keeps every ch_ready low while reset is held,
    // even though the output stage itself reads as empty then.
    assign arb_en = load_en && tb_rst_n;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (tb_clk),
        .rst_n     (tb_rst_n),
        .req       (ch_valid),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign gnt_any  = |grant;
    assign ch_ready = grant;

    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            out_state_q <= OUT_EMPTY;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (load_en) begin
            if (gnt_any) begin
                out_state_q <= OUT_FULL;
                out_data_q  <= ch_data_arr[grant_idx];
                out_ch_q    <= grant_idx;
            end else begin
                // Drained with nothing to refill: payload and tag are left
                // as they were, only the valid drops.
                out_state_q <= OUT_EMPTY;
            end
        end
    end

    assign out_valid = (out_state_q == OUT_FULL);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    // ------------------------------------------------------------------
    // Per-channel accepted-beat counters
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;

            // A grant is only ever issued to a valid channel, so grant[gi]
            // is exactly the handshake on that channel.
            always_ff @(posedge tb_clk or negedge tb_rst_n) begin
                if (!tb_rst_n) begin
                    cnt_q <= '0;
                end else if (clr_err) begin
                    cnt_q <= grant[gi] ? CNT_W'(1) : '0;
                end else if (grant[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign ch_count[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------
    wd_state_e       wd_state_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic            timeout_err_q;
    logic            stall;
    logic            trip_now;

    assign stall = out_valid && !out_ready;

    // wd_cnt_q is the length of the current stall run, saturating at
    // TIMEOUT. The trip fires exactly once per run, on the cycle that makes
    // the run TIMEOUT long; a run that keeps going afterwards cannot re-trip.
    assign trip_now = stall && (wd_cnt_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            wd_state_q    <= WD_IDLE;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // Run length
            if (!stall) begin
                wd_cnt_q <= '0;
            end else if (clr_err && !trip_now) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != WD_W'(TIMEOUT)) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end

            // State and flag; a trip in the clearing cycle wins.
            if (trip_now) begin
                wd_state_q    <= WD_TRIPPED;
                timeout_err_q <= 1'b1;
            end else if (clr_err) begin
                wd_state_q    <= WD_IDLE;
                timeout_err_q <= 1'b0;
            end else begin
                case (wd_state_q)
                    WD_IDLE: begin
                        if (stall) begin
                            wd_state_q <= WD_COUNTING;
                        end
                    end
                    WD_COUNTING: begin
                        if (!stall) begin
                            wd_state_q <= WD_IDLE;
                        end
                    end
                    WD_TRIPPED: begin
                        wd_state_q <= WD_TRIPPED;
                    end
                    default: begin
                        wd_state_q <= WD_IDLE;
                    end
                endcase
            end
        end
    end

    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tb_stim_mux.sv
module tb_tb_stim_mux;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int CH_W    = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     tb_clk    = 1'b0;
    logic                     tb_rst_n  = 1'b0;
    logic [NUM_CH-1:0]        ch_valid  = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data   = '0;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready = 1'b0;
    logic [NUM_CH*CNT_W-1:0]  ch_count;
    logic                     timeout_err;
    logic                     clr_err   = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 tb_clk = ~tb_clk;

    tb_stim_mux #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .tb_clk      (tb_clk),
        .tb_rst_n    (tb_rst_n),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_ready    (ch_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_ready   (out_ready),
        .ch_count    (ch_count),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    // ---------------- behavioural reference model ----------------
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_ch;
    int          m_cnt [NUM_CH];
    int          m_run;     // length of the current stall run
    bit          m_err;
    logic [3:0]  exp_ready;
    logic [3:0]  obs_ready;

    task automatic m_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_ch = 0; m_run = 0; m_err = 0;
        for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
    endtask

    // Channel that would be served this cycle, or -1.
    function automatic int m_pick(input logic [3:0] v, input logic rdy);
        if (m_valid && !rdy) return -1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[(m_ptr + k) % NUM_CH]) return (m_ptr + k) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one clock cycle and advances the model; leaves the time at
    // posedge + 1 with exp_ready / obs_ready describing the cycle just done.
    task automatic run_cycle(input logic [3:0] v, input logic rdy, input logic clr,
                             input logic [127:0] d);
        int g;
        bit stall;
        ch_valid = v; out_ready = rdy; clr_err = clr; ch_data = d;
        #1;
        g = m_pick(v, rdy);
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        obs_ready = ch_ready;
        @(posedge tb_clk);
        #1;
        stall = m_valid && !rdy;
        if (stall) m_run++; else m_run = 0;
        if (stall && m_run == TIMEOUT) m_err = 1;
        else if (clr) begin m_err = 0; m_run = 0; end
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr) m_cnt[i] = (i == g) ? 1 : 0;
            else if (i == g && m_cnt[i] < CNT_MAX) m_cnt[i]++;
        end
        if (!m_valid || rdy) begin
            if (g >= 0) begin
                m_valid = 1; m_data = d[g*32 +: 32]; m_ch = g; m_ptr = (g + 1) % NUM_CH;
            end else begin
                m_valid = 0;
            end
        end
        cyc++;
        $display("cyc %0d v=%b rdy=%b clr=%b ready=%b out_v=%b ch=%0d data=%h err=%b",
                 cyc, v, rdy, clr, obs_ready, out_valid, out_ch, out_data, timeout_err);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        m_reset();
        @(posedge tb_clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (ch_count !== '0) begin errors++; $display("FAIL rst_ch_count got %h want 0", ch_count); end
        tb_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) run_cycle(4'b1111, 1'b1, 1'b0, rand_data());
        // Mid-stream reset: outputs must clear without waiting for a clock.
        tb_rst_n = 1'b0; ch_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_out_data got %h want 0", out_data); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL midrst_out_ch got %0d want 0", out_ch); end
        checks++; if (ch_count !== '0) begin errors++; $display("FAIL midrst_ch_count got %h want 0", ch_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", timeout_err); end
        checks++; if (ch_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ch_ready got %b want 0000", ch_ready); end
        m_reset();
        @(posedge tb_clk); #1;
        tb_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_cycle(4'b1111, 1'b1, 1'b0, rand_data());
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'(k % 4)) begin
                errors++; $display("FAIL rr_order beat %0d got v=%b ch=%0d want v=1 ch=%0d", k, out_valid, out_ch, k % 4);
            end
            checks++; if (out_data !== m_data) begin errors++; $display("FAIL rr_data got %h want %h", out_data, m_data); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        d = rand_data();
        d[31:0] = 32'hA5A5_0001;
        run_cycle(4'b0001, 1'b1, 1'b0, d);
        checks++; if (out_data !== 32'hA5A5_0001 || out_ch !== 2'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_load got v=%b ch=%0d data=%h want v=1 ch=0 data=a5a50001", out_valid, out_ch, out_data);
        end
        for (int k = 0; k < 5; k++) begin
            run_cycle(4'b1111, 1'b0, 1'b0, rand_data());
            checks++; if (obs_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready got %b want 0000", obs_ready); end
            checks++; if (out_data !== 32'hA5A5_0001 || out_ch !== 2'd0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold got v=%b ch=%0d data=%h want v=1 ch=0 data=a5a50001", out_valid, out_ch, out_data);
            end
        end
        run_cycle(4'b1111, 1'b1, 1'b0, rand_data());
        checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b want 0010", obs_ready); end
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== m_data) begin
            errors++; $display("FAIL bp_release got v=%b ch=%0d data=%h want v=1 ch=1 data=%h", out_valid, out_ch, out_data, m_data);
        end
    endtask

    task automatic test_sparse();
        run_cycle(4'b0000, 1'b1, 1'b1, rand_data());
        for (int k = 0; k < 10; k++) begin
            run_cycle(4'b0100, 1'b1, 1'b0, rand_data());
            checks++; if (obs_ready !== 4'b0100 || out_ch !== 2'd2 || out_valid !== 1'b1) begin
                errors++; $display("FAIL sparse beat %0d got ready=%b v=%b ch=%0d want ready=0100 v=1 ch=2", k, obs_ready, out_valid, out_ch);
            end
        end
        checks++; if (ch_count !== 16'h0A00) begin errors++; $display("FAIL sparse_counts got %h want 0a00", ch_count); end
    endtask

    task automatic test_watchdog();
        run_cycle(4'b1111, 1'b1, 1'b0, rand_data());
        for (int k = 0; k < 7; k++) run_cycle(4'b1111, 1'b0, 1'b0, rand_data());
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_7_stalls got %b want 0", timeout_err); end
        run_cycle(4'b1111, 1'b1, 1'b0, rand_data());
        for (int k = 0; k < 7; k++) run_cycle(4'b1111, 1'b0, 1'b0, rand_data());
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_pre_trip got %b want 0", timeout_err); end
        run_cycle(4'b1111, 1'b0, 1'b0, rand_data());
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_trip got %b want 1", timeout_err); end
        run_cycle(4'b1111, 1'b0, 1'b0, rand_data());
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b want 1", timeout_err); end
        run_cycle(4'b1111, 1'b0, 1'b1, rand_data());
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_clear got %b want 0", timeout_err); end
        // A trip landing on the clearing cycle must survive the clear.
        run_cycle(4'b1111, 1'b1, 1'b0, rand_data());
        for (int k = 0; k < 7; k++) run_cycle(4'b1111, 1'b0, 1'b0, rand_data());
        run_cycle(4'b1111, 1'b0, 1'b1, rand_data());
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL wd_set_wins got %b want 1", timeout_err); end
        run_cycle(4'b1111, 1'b1, 1'b1, rand_data());
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wd_final_clear got %b want 0", timeout_err); end
    endtask

    task automatic test_saturation();
        run_cycle(4'b0000, 1'b1, 1'b1, rand_data());
        for (int k = 0; k < 20; k++) run_cycle(4'b0010, 1'b1, 1'b0, rand_data());
        checks++; if (ch_count[1*CNT_W +: CNT_W] !== 4'd15) begin
            errors++; $display("FAIL sat_count got %0d want 15", ch_count[1*CNT_W +: CNT_W]);
        end
        run_cycle(4'b0010, 1'b1, 1'b1, rand_data());
        checks++; if (ch_count !== 16'h0010) begin errors++; $display("FAIL clr_with_accept got %h want 0010", ch_count); end
    endtask

    task automatic test_random();
        int thr;
        for (int k = 0; k < 400; k++) begin
            thr = ((k / 50) % 2 == 0) ? 80 : 8;
            run_cycle(4'($urandom), 1'($urandom_range(0, 99) < thr), 1'($urandom_range(0, 49) == 0), rand_data());
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, obs_ready, exp_ready); end
            checks++; if (out_valid !== m_valid || out_ch !== 2'(m_ch) || out_data !== m_data) begin
                errors++; $display("FAIL rnd_out cyc %0d got v=%b ch=%0d data=%h want v=%b ch=%0d data=%h",
                                   cyc, out_valid, out_ch, out_data, m_valid, m_ch, m_data);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                checks++; if (ch_count[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i])) begin
                    errors++; $display("FAIL rnd_count%0d cyc %0d got %0d want %0d", i, cyc, ch_count[i*CNT_W +: CNT_W], m_cnt[i]);
                end
            end
            checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", cyc, timeout_err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_sparse();
        test_watchdog();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
